// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID pipeline register, with stall, redirect/flush and ECALL halt.
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALT} fetchState_t;

  fetchState_t r_state, w_stateNext;
  logic [63:0] r_pc, w_pcNext;
  logic [63:0] r_ifIdPc, w_ifIdPcNext;
  logic [31:0] r_ifIdInstr, w_ifIdInstrNext;
  logic        r_ifIdValid, w_ifIdValidNext;
  logic [31:0] r_fetchCount, w_fetchCountNext;
  logic [63:0] w_redirectPc;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign w_redirectPc = branch_target & ~64'h3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_ifIdPc     <= 64'h0;
      r_ifIdInstr  <= NOP_INSTR;
      r_ifIdValid  <= 1'b0;
      r_fetchCount <= 32'h0;
    end else begin
      r_state      <= w_stateNext;
      r_pc         <= w_pcNext;
      r_ifIdPc     <= w_ifIdPcNext;
      r_ifIdInstr  <= w_ifIdInstrNext;
      r_ifIdValid  <= w_ifIdValidNext;
      r_fetchCount <= w_fetchCountNext;
    end
  end

  always_comb begin
    w_stateNext      = r_state;
    w_pcNext         = r_pc;
    w_ifIdPcNext     = r_ifIdPc;
    w_ifIdInstrNext  = r_ifIdInstr;
    w_ifIdValidNext  = r_ifIdValid;
    w_fetchCountNext = r_fetchCount;

    // A redirect beats stall in both states; in HALT it means the ECALL was wrong-path.
    if (branch_taken) begin
      w_stateNext     = RUN;
      w_pcNext        = w_redirectPc;
      w_ifIdPcNext    = 64'h0;
      w_ifIdInstrNext = NOP_INSTR;
      w_ifIdValidNext = 1'b0;
    end else if (!stall) begin
      case (r_state)
        RUN: begin
          w_ifIdPcNext     = r_pc;
          w_ifIdInstrNext  = imem_rdata;
          w_ifIdValidNext  = 1'b1;
          w_fetchCountNext = r_fetchCount + 32'd1;
          if (imem_rdata == HALT_INSTR) begin
            w_stateNext = HALT;
          end else begin
            w_pcNext = r_pc + 64'd4;
          end
        end
        HALT: begin
          w_ifIdPcNext    = 64'h0;
          w_ifIdInstrNext = NOP_INSTR;
          w_ifIdValidNext = 1'b0;
        end
        default: begin
          w_stateNext = RUN;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_pc    = r_ifIdPc;
  assign if_id_instr = r_ifIdInstr;
  assign if_id_valid = r_ifIdValid;
  assign halted      = (r_state == HALT);
  assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a small combinational instruction memory
// and hand-computed expectations for fetch, stall, redirect, halt and reset.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];
  int checkCount;
  int passCount;

  if_fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [63:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                           input logic valid, input logic [31:0] count, input logic [63:0] addr);
    checkOutput({tag, ".pc"}, if_id_pc, pc);
    checkOutput({tag, ".instr"}, {32'h0, if_id_instr}, {32'h0, instr});
    checkOutput({tag, ".valid"}, {63'h0, if_id_valid}, {63'h0, valid});
    checkOutput({tag, ".count"}, {32'h0, fetch_count}, {32'h0, count});
    checkOutput({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
    mem[0]  = 32'h00500093;
    mem[1]  = 32'h00A00113;
    mem[2]  = 32'h002081B3;
    mem[4]  = 32'h00000073;
    mem[6]  = 32'h00300293;
    mem[8]  = 32'h00200213;
    mem[16] = 32'h00100193;

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'h0);
    tick();
    tick();
    checkIfId("reset", 64'h0, 32'h00000013, 1'b0, 32'd0, 64'h0);
    checkOutput("reset.halted", {63'h0, halted}, 64'h0);
    reset = 1'b1;

    tick();
    checkIfId("fetch0", 64'h0, 32'h00500093, 1'b1, 32'd1, 64'h4);
    tick();
    checkIfId("fetch4", 64'h4, 32'h00A00113, 1'b1, 32'd2, 64'h8);

    applyStimulus(1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkIfId("stall", 64'h4, 32'h00A00113, 1'b1, 32'd2, 64'h8);
    end
    applyStimulus(1'b0, 1'b0, 64'h0);
    tick();
    checkIfId("fetch8", 64'h8, 32'h002081B3, 1'b1, 32'd3, 64'hC);

    applyStimulus(1'b1, 1'b1, 64'h43);
    tick();
    checkIfId("brStall", 64'h0, 32'h00000013, 1'b0, 32'd3, 64'h40);
    applyStimulus(1'b0, 1'b0, 64'h0);
    tick();
    checkIfId("fetch40", 64'h40, 32'h00100193, 1'b1, 32'd4, 64'h44);

    applyStimulus(1'b0, 1'b1, 64'h10);
    tick();
    checkIfId("br10", 64'h0, 32'h00000013, 1'b0, 32'd4, 64'h10);
    applyStimulus(1'b0, 1'b0, 64'h0);
    tick();
    checkIfId("ecall", 64'h10, 32'h00000073, 1'b1, 32'd5, 64'h10);
    checkOutput("ecall.halted", {63'h0, halted}, 64'h1);

    applyStimulus(1'b1, 1'b0, 64'h0);
    tick();
    checkIfId("haltStall", 64'h10, 32'h00000073, 1'b1, 32'd5, 64'h10);
    applyStimulus(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("haltBubble.instr", {32'h0, if_id_instr}, 64'h13);
      checkOutput("haltBubble.valid", {63'h0, if_id_valid}, 64'h0);
      checkOutput("haltBubble.count", {32'h0, fetch_count}, 64'd5);
      checkOutput("haltBubble.addr", imem_addr, 64'h10);
      checkOutput("haltBubble.halted", {63'h0, halted}, 64'h1);
    end

    applyStimulus(1'b0, 1'b1, 64'h20);
    tick();
    checkIfId("haltCancel", 64'h0, 32'h00000013, 1'b0, 32'd5, 64'h20);
    checkOutput("haltCancel.halted", {63'h0, halted}, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    tick();
    checkIfId("fetch20", 64'h20, 32'h00200213, 1'b1, 32'd6, 64'h24);

    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checkIfId("brTop", 64'h0, 32'h00000013, 1'b0, 32'd6, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 64'h0);
    tick();
    checkIfId("pcWrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h00000013, 1'b1, 32'd7, 64'h0);

    applyStimulus(1'b0, 1'b1, 64'h18);
    tick();
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("pre.addr", imem_addr, 64'h18);
    reset = 1'b0;
    #1;
    checkIfId("asyncReset", 64'h0, 32'h00000013, 1'b0, 32'd0, 64'h0);
    checkOutput("asyncReset.halted", {63'h0, halted}, 64'h0);
    #1;
    reset = 1'b1;
    tick();
    checkIfId("restart", 64'h0, 32'h00500093, 1'b1, 32'd1, 64'h4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RISC_V_Processor pipeline. It holds the PC, drives the instruction-memory read address, and registers the fetched word into the IF/ID pipeline register that feeds decode. It honours stall from hazard detection and redirect/flush from branch resolution. It halts on ECALL so that benches can detect end of program.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) inserted on flush and halt.
HALT_INSTR, 32'h00000073, ECALL encoding that halts fetch.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
stall  input  1  hold PC and IF/ID (load-use hazard).
branch_taken  input  1  redirect request from branch resolution; also flushes IF/ID.
branch_target  input  64  redirect PC; bits[1:0] ignored and forced to 0.
imem_addr  output  64  current PC; combinational from the PC register.
imem_rdata  input  32  instruction at imem_addr; combinational read, same cycle.
if_id_pc  output  64  PC of the instruction held in IF/ID.
if_id_instr  output  32  instruction held in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction (not a bubble).
halted  output  1  fetch is stopped on HALT_INSTR.
fetch_count  output  32  number of instructions written into IF/ID with valid=1.

Behaviour:
- Reset (reset=0, asynchronous, takes effect regardless of clk):
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fetch_count=0, state=RUN.
- States: RUN, HALT. halted=1 exactly when state=HALT.
- Rising-edge priority in RUN, highest first:
  - branch_taken=1: pc<={branch_target[63:2],2'b00}; if_id_instr<=NOP_INSTR; if_id_pc<=0; if_id_valid<=0. Applies even when stall=1. fetch_count unchanged.
  - stall=1: pc, IF/ID and fetch_count hold.
  - imem_rdata==HALT_INSTR: if_id_pc<=pc; if_id_instr<=HALT_INSTR; if_id_valid<=1; fetch_count+=1; pc holds; state<=HALT. The ECALL itself propagates down the pipe.
  - Otherwise: if_id_pc<=pc; if_id_instr<=imem_rdata; if_id_valid<=1; pc<=pc+4; fetch_count+=1.
- HALT:
  - Each edge with stall=0 and branch_taken=0: IF/ID<=bubble (NOP_INSTR, valid 0). pc holds.
  - stall=1: IF/ID holds, so the ECALL is not lost while decode is stalled.
  - branch_taken=1: the ECALL was wrong-path. Perform the redirect and flush as in RUN, state<=RUN, halted<=0.
- Latency: an instruction whose address is presented on imem_addr appears on if_id_instr one cycle later when not stalled.
- pc+4 wraps modulo 2^64. fetch_count wraps from 32'hFFFFFFFF to 0.
- Reset asserted mid-operation discards IF/ID contents and HALT state immediately. After reset is released, the first fetch occurs at the first rising edge.
- No X propagation: all registers are defined after reset. Outputs derive only from registers, except imem_addr, which is a direct copy of pc.

Test Plan:
- Reset then sequential fetch: imem returns 32'h00500093, 32'h00A00113, 32'h002081B3 at 0x0, 0x4, 0x8 → if_id_pc=0,4,8 on successive edges; if_id_valid=1; fetch_count=3; imem_addr=0xC.
- Stall: assert stall for 2 cycles while pc=0x8 → imem_addr stays 0x8; if_id_pc stays 0x4; fetch_count is unchanged; fetch resumes with if_id_pc=0x8.
- Branch with simultaneous stall: branch_taken=1, stall=1, branch_target=0x43 → next edge pc=0x40; if_id_instr=32'h00000013; if_id_valid=0; following edge if_id_pc=0x40.
- Halt: instruction 32'h00000073 at 0x10 → halted=1 after that edge; if_id_instr=32'h00000073; pc stays 0x10 for 5 cycles; bubbles follow; fetch_count stops incrementing.
- Halt cancel: in HALT, assert branch_taken with branch_target=0x20 → halted=0; pc=0x20; fetch resumes at 0x20.
- Async reset mid-run: drive reset=0 between clock edges at pc=0x18 → pc=0, if_id_valid=0 and fetch_count=0 before the next edge; fetch restarts from 0x0 after release.
